uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-producing clients. It accepts one byte at a time from the winning requester over a valid/ready handshake, launches it on the transmitter with a one-cycle start pulse, then waits for frame completion before arbitrating again. It sits between on-chip clients (command responder, status reporter, debug port) and the single `uart_tx` instance.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-producing clients, the UART TX arbiter and the transmitter.
// master = arbiter side, slave = clients/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_busy;
    logic                          tx_done;
    logic [ID_W-1:0]               grant_id;
    logic                          grant_valid;

    modport master (
        input  req_valid, req_data, req_lock, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_id, grant_valid
    );

    modport slave (
        output req_valid, req_data, req_lock, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, grant_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte clients.
// Optional grant locking is compiled in with `define UART_ARB_LOCK_EN.
//
// state     | meaning
// IDLE      | arbitrate; accept one byte from the winner when tx is not busy
// LAUNCH    | tx_start pulse, byte held on tx_data
// WAIT_DONE | frame in progress, wait for tx_done
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic             clk,
    input logic             reset,
    uart_tx_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         r_grant_id;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_start;
    logic [ID_W-1:0]         w_scan_ptr;
    logic [ID_W-1:0]         w_win;
    logic [ID_W-1:0]         w_rr_next;
    logic [NUM_REQ-1:0]      w_eligible;
    logic [NUM_REQ-1:0]      w_ready;
    logic                    w_found;
    logic                    w_accept;
    logic                    w_rr_advance;
    logic                    w_grant_valid;

    // NUM_REQ need not be a power of two, so wrap by compare.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

`ifdef UART_ARB_LOCK_EN
    logic            r_lock_active;
    logic [ID_W-1:0] r_lock_owner;
    logic            w_lock_drop;

    assign w_lock_drop = r_lock_active && !bus.req_valid[r_lock_owner];

    // A departed owner releases the lock and arbitration restarts just past it.
    always_comb begin
        w_eligible = bus.req_valid;
        w_scan_ptr = r_rr_ptr;
        if (r_lock_active) begin
            if (w_lock_drop) begin
                w_scan_ptr = next_id(r_lock_owner);
            end else begin
                w_eligible               = '0;
                w_eligible[r_lock_owner] = 1'b1;
            end
        end
    end

    assign w_rr_advance = (r_state == WAIT_DONE && bus.tx_done && !r_lock_active) ||
                          (r_state == IDLE && w_lock_drop);
    assign w_rr_next    = (r_state == IDLE) ? next_id(r_lock_owner) : next_id(r_grant_id);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_active <= 1'b0;
            r_lock_owner  <= '0;
        end else if (w_accept) begin
            r_lock_active <= bus.req_lock[w_win];
            r_lock_owner  <= w_win;
        end else if (r_state == IDLE && w_lock_drop) begin
            r_lock_active <= 1'b0;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = ^bus.req_lock;
    assign w_eligible    = bus.req_valid;
    assign w_scan_ptr    = r_rr_ptr;
    assign w_rr_advance  = (r_state == WAIT_DONE) && bus.tx_done;
    assign w_rr_next     = next_id(r_grant_id);
`endif

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(w_scan_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_found && !bus.tx_busy && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_ready       = '0;
        w_grant_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_ready[w_win] = 1'b1;
                    w_state_next   = LAUNCH;
                end
            end
            LAUNCH: begin
                w_grant_valid = 1'b1;
                w_state_next  = WAIT_DONE;
            end
            WAIT_DONE: begin
                w_grant_valid = 1'b1;
                if (bus.tx_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_tx_start <= w_accept;
            if (w_accept) begin
                r_tx_data  <= bus.req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_grant_id <= w_win;
            end
            if (w_rr_advance) r_rr_ptr <= w_rr_next;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_valid = w_grant_valid && !reset;
endmodule
